framebuffer_fragment_feeder: RTL and testbench

Upstream neighbour of the framebuffer writer. It accepts per-pixel writes (x, y, colour) from the pixel pipeline and turns each into a fragment. Each fragment carries a linear pixel-index address, so the writer can merge fragments into bus-wide lines and issue AXI writes. It also generates framebuffer clears internally: the whole screen, or the snapshotted scissor rectangle, is emitted as one fragment packet.

---
 rtl/rasterix_fb_pkg.sv | 18 +
 rtl/framebuffer_addr_pipe.sv | 91 +++++++++
 rtl/framebuffer_fragment_feeder.sv | 205 ++++++++++++++++++++
 tb/tb_framebuffer_fragment_feeder.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rasterix_fb_pkg.sv
// Shared definitions for the framebuffer feeder and writer.
// Holds the feeder state encoding and the fragment field widths so both
// sides of the fragment stream agree on the layout.
package rasterix_fb_pkg;

    localparam int FB_ADDR_WIDTH  = 32;
    localparam int FB_X_BIT_WIDTH = 11;
    localparam int FB_Y_BIT_WIDTH = 11;
    localparam int FB_PIXEL_WIDTH = 16;

    typedef enum logic [1:0] {
        FB_PASS        = 2'd0,
        FB_CLEAR_PEND  = 2'd1,
        FB_CLEAR       = 2'd2,
        FB_CLEAR_DRAIN = 2'd3
    } fb_feed_state_t;

endpackage

// File: rtl/framebuffer_addr_pipe.sv
// Two-stage multiply-add pipeline turning (x, y) into a linear pixel index.
// Stage 1 registers the fragment fields and y*xres; stage 2 (the output
// register) adds x.
// Ports:
//   aclk, resetn          clock, synchronous active-low reset
//   xres                  screen width used as the row stride
//   s_* (valid/ready)     fragment fields in
//   m_* (valid/ready)     fragment fields out plus m_addr
//   empty                 both stages hold no fragment
// Handshake: a beat transfers on a rising edge where valid && ready; a
// stage loads when it is empty or the stage after it is advancing, and the
// output fields stay stable while m_valid && !m_ready.
module framebuffer_addr_pipe
    import rasterix_fb_pkg::*;
#(
    parameter int ADDR_WIDTH  = FB_ADDR_WIDTH,
    parameter int X_BIT_WIDTH = FB_X_BIT_WIDTH,
    parameter int Y_BIT_WIDTH = FB_Y_BIT_WIDTH,
    parameter int PIXEL_WIDTH = FB_PIXEL_WIDTH
) (
    input  logic                   aclk,
    input  logic                   resetn,
    input  logic [X_BIT_WIDTH-1:0] xres,
    input  logic                   s_valid,
    output logic                   s_ready,
    input  logic [PIXEL_WIDTH-1:0] s_data,
    input  logic                   s_strb,
    input  logic                   s_last,
    input  logic [X_BIT_WIDTH-1:0] s_xpos,
    input  logic [Y_BIT_WIDTH-1:0] s_ypos,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic [PIXEL_WIDTH-1:0] m_data,
    output logic                   m_strb,
    output logic                   m_last,
    output logic [X_BIT_WIDTH-1:0] m_xpos,
    output logic [Y_BIT_WIDTH-1:0] m_ypos,
    output logic [ADDR_WIDTH-1:0]  m_addr,
    output logic                   empty
);
    localparam int PW = X_BIT_WIDTH + Y_BIT_WIDTH;

    logic                   p1_valid;
    logic [PIXEL_WIDTH-1:0] p1_data;
    logic                   p1_strb;
    logic                   p1_last;
    logic [X_BIT_WIDTH-1:0] p1_xpos;
    logic [Y_BIT_WIDTH-1:0] p1_ypos;
    logic [PW-1:0]          p1_prod;

    logic          adv2;
    logic [PW-1:0] prod_in;

    assign adv2    = !m_valid || m_ready;
    assign s_ready = !p1_valid || adv2;
    assign empty   = !p1_valid && !m_valid;
    assign prod_in = PW'(s_ypos) * PW'(xres);

    always_ff @(posedge aclk) begin
        if (!resetn) begin
            p1_valid <= 1'b0;
            m_valid  <= 1'b0;
        end else begin
            if (s_ready) begin
                p1_valid <= s_valid;
                if (s_valid) begin
                    p1_data <= s_data;
                    p1_strb <= s_strb;
                    p1_last <= s_last;
                    p1_xpos <= s_xpos;
                    p1_ypos <= s_ypos;
                    p1_prod <= prod_in;
                end
            end
            if (adv2) begin
                m_valid <= p1_valid;
                if (p1_valid) begin
                    m_data <= p1_data;
                    m_strb <= p1_strb;
                    m_last <= p1_last;
                    m_xpos <= p1_xpos;
                    m_ypos <= p1_ypos;
                    // Sum is formed at address width so carries are kept
                    // when the address is wider than the product.
                    m_addr <= ADDR_WIDTH'(p1_prod) + ADDR_WIDTH'(p1_xpos);
                end
            end
        end
    end

endmodule

// File: rtl/framebuffer_fragment_feeder.sv
// Feeds fragments to the framebuffer writer: forwards pipeline pixels with
// a linear address, and injects full-screen or scissor clears as a single
// fragment packet.
// Ports:
//   aclk, resetn              clock, synchronous active-low reset
//   conf*                     screen size and scissor rectangle (end exclusive)
//   cmdClear/cmdClearColor    single-cycle clear request and its colour
//   cmdBusy                   clear pending, running or draining
//   s_pix_*                   pixel input stream
//   m_frag_*                  fragment output stream with m_frag_taddr
//   dbg_state                 current feeder state
// Handshake: a beat transfers on a rising edge where tvalid && tready.
module framebuffer_fragment_feeder
    import rasterix_fb_pkg::*;
#(
    parameter int ADDR_WIDTH  = FB_ADDR_WIDTH,
    parameter int X_BIT_WIDTH = FB_X_BIT_WIDTH,
    parameter int Y_BIT_WIDTH = FB_Y_BIT_WIDTH,
    parameter int PIXEL_WIDTH = FB_PIXEL_WIDTH
) (
    input  logic                   aclk,
    input  logic                   resetn,
    input  logic [X_BIT_WIDTH-1:0] confXResolution,
    input  logic [Y_BIT_WIDTH-1:0] confYResolution,
    input  logic                   confEnableScissor,
    input  logic [X_BIT_WIDTH-1:0] confScissorStartX,
    input  logic [Y_BIT_WIDTH-1:0] confScissorStartY,
    input  logic [X_BIT_WIDTH-1:0] confScissorEndX,
    input  logic [Y_BIT_WIDTH-1:0] confScissorEndY,
    input  logic                   cmdClear,
    input  logic [PIXEL_WIDTH-1:0] cmdClearColor,
    output logic                   cmdBusy,
    input  logic                   s_pix_tvalid,
    output logic                   s_pix_tready,
    input  logic [PIXEL_WIDTH-1:0] s_pix_tdata,
    input  logic                   s_pix_tstrb,
    input  logic [X_BIT_WIDTH-1:0] s_pix_txpos,
    input  logic [Y_BIT_WIDTH-1:0] s_pix_typos,
    input  logic                   s_pix_tlast,
    output logic                   m_frag_tvalid,
    input  logic                   m_frag_tready,
    output logic [PIXEL_WIDTH-1:0] m_frag_tdata,
    output logic                   m_frag_tstrb,
    output logic                   m_frag_tlast,
    output logic [X_BIT_WIDTH-1:0] m_frag_txpos,
    output logic [Y_BIT_WIDTH-1:0] m_frag_typos,
    output logic [ADDR_WIDTH-1:0]  m_frag_taddr,
    output logic [1:0]             dbg_state
);
    fb_feed_state_t state, state_next;

    logic                   pkt_open;
    logic [PIXEL_WIDTH-1:0] clr_color;
    logic [X_BIT_WIDTH-1:0] rsx, rex, cx;
    logic [Y_BIT_WIDTH-1:0] rsy, rey, cy;

    logic                   pipe_s_valid, pipe_s_ready, pipe_empty;
    logic [PIXEL_WIDTH-1:0] pipe_s_data;
    logic                   pipe_s_strb, pipe_s_last;
    logic [X_BIT_WIDTH-1:0] pipe_s_xpos;
    logic [Y_BIT_WIDTH-1:0] pipe_s_ypos;

    logic pass_through, pix_accept, inj_valid, inj_accept;
    logic region_empty, x_end_hit, y_end_hit, clr_last, open_eff;

    assign region_empty = (rsx >= rex) || (rsy >= rey);
    assign x_end_hit    = ({1'b0, cx} + {{X_BIT_WIDTH{1'b0}}, 1'b1}) == {1'b0, rex};
    assign y_end_hit    = ({1'b0, cy} + {{Y_BIT_WIDTH{1'b0}}, 1'b1}) == {1'b0, rey};
    assign clr_last     = x_end_hit && y_end_hit;

    // A beat accepted in the same cycle as cmdClear decides whether the
    // packet is still open.
    assign open_eff = pix_accept ? !s_pix_tlast : pkt_open;

    always_ff @(posedge aclk) begin
        if (!resetn) begin
            state <= FB_PASS;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            FB_PASS: begin
                if (cmdClear) begin
                    state_next = open_eff ? FB_CLEAR_PEND : FB_CLEAR;
                end
            end
            FB_CLEAR_PEND: begin
                if (pix_accept && s_pix_tlast) begin
                    state_next = FB_CLEAR;
                end
            end
            FB_CLEAR: begin
                if (region_empty || (inj_accept && clr_last)) begin
                    state_next = FB_CLEAR_DRAIN;
                end
            end
            FB_CLEAR_DRAIN: begin
                if (pipe_empty) begin
                    state_next = FB_PASS;
                end
            end
            default: state_next = FB_PASS;
        endcase
    end

    always_comb begin
        pass_through = (state == FB_PASS) || (state == FB_CLEAR_PEND);
        s_pix_tready = resetn && pass_through && pipe_s_ready;
        pix_accept   = s_pix_tvalid && s_pix_tready;
        inj_valid    = (state == FB_CLEAR) && !region_empty;
        inj_accept   = inj_valid && pipe_s_ready;
        cmdBusy      = (state != FB_PASS);
        dbg_state    = state;
        if (pass_through) begin
            pipe_s_valid = s_pix_tvalid;
            pipe_s_data  = s_pix_tdata;
            pipe_s_strb  = s_pix_tstrb;
            pipe_s_last  = s_pix_tlast;
            pipe_s_xpos  = s_pix_txpos;
            pipe_s_ypos  = s_pix_typos;
        end else begin
            pipe_s_valid = inj_valid;
            pipe_s_data  = clr_color;
            pipe_s_strb  = 1'b1;
            pipe_s_last  = clr_last;
            pipe_s_xpos  = cx;
            pipe_s_ypos  = cy;
        end
    end

    always_ff @(posedge aclk) begin
        if (!resetn) begin
            pkt_open  <= 1'b0;
            clr_color <= '0;
            rsx       <= '0;
            rsy       <= '0;
            rex       <= '0;
            rey       <= '0;
            cx        <= '0;
            cy        <= '0;
        end else begin
            if (pix_accept) begin
                pkt_open <= !s_pix_tlast;
            end
            if ((state == FB_PASS) && cmdClear) begin
                clr_color <= cmdClearColor;
                if (confEnableScissor) begin
                    rsx <= confScissorStartX;
                    rsy <= confScissorStartY;
                    rex <= confScissorEndX;
                    rey <= confScissorEndY;
                    cx  <= confScissorStartX;
                    cy  <= confScissorStartY;
                end else begin
                    rsx <= '0;
                    rsy <= '0;
                    rex <= confXResolution;
                    rey <= confYResolution;
                    cx  <= '0;
                    cy  <= '0;
                end
            end else if (inj_accept) begin
                // x-major scan: wrap x to the region start, then step y.
                if (x_end_hit) begin
                    cx <= rsx;
                    cy <= cy + {{(Y_BIT_WIDTH-1){1'b0}}, 1'b1};
                end else begin
                    cx <= cx + {{(X_BIT_WIDTH-1){1'b0}}, 1'b1};
                end
            end
        end
    end

    framebuffer_addr_pipe #(
        .ADDR_WIDTH  (ADDR_WIDTH),
        .X_BIT_WIDTH (X_BIT_WIDTH),
        .Y_BIT_WIDTH (Y_BIT_WIDTH),
        .PIXEL_WIDTH (PIXEL_WIDTH)
    ) u_pipe (
        .aclk    (aclk),
        .resetn  (resetn),
        .xres    (confXResolution),
        .s_valid (pipe_s_valid),
        .s_ready (pipe_s_ready),
        .s_data  (pipe_s_data),
        .s_strb  (pipe_s_strb),
        .s_last  (pipe_s_last),
        .s_xpos  (pipe_s_xpos),
        .s_ypos  (pipe_s_ypos),
        .m_valid (m_frag_tvalid),
        .m_ready (m_frag_tready),
        .m_data  (m_frag_tdata),
        .m_strb  (m_frag_tstrb),
        .m_last  (m_frag_tlast),
        .m_xpos  (m_frag_txpos),
        .m_ypos  (m_frag_typos),
        .m_addr  (m_frag_taddr),
        .empty   (pipe_empty)
    );

endmodule

// File: tb/tb_framebuffer_fragment_feeder.sv
module tb_framebuffer_fragment_feeder;
    localparam int AW = 32;
    localparam int XW = 11;
    localparam int YW = 11;
    localparam int PW = 16;

    logic          aclk;
    logic          resetn;
    logic [XW-1:0] confXResolution;
    logic [YW-1:0] confYResolution;
    logic          confEnableScissor;
    logic [XW-1:0] confScissorStartX, confScissorEndX;
    logic [YW-1:0] confScissorStartY, confScissorEndY;
    logic          cmdClear;
    logic [PW-1:0] cmdClearColor;
    logic          cmdBusy;
    logic          s_pix_tvalid, s_pix_tready, s_pix_tstrb, s_pix_tlast;
    logic [PW-1:0] s_pix_tdata;
    logic [XW-1:0] s_pix_txpos;
    logic [YW-1:0] s_pix_typos;
    logic          m_frag_tvalid, m_frag_tready, m_frag_tstrb, m_frag_tlast;
    logic [PW-1:0] m_frag_tdata;
    logic [XW-1:0] m_frag_txpos;
    logic [YW-1:0] m_frag_typos;
    logic [AW-1:0] m_frag_taddr;
    logic [1:0]    dbg_state;

    int n_cmp  = 0;
    int n_fail = 0;
    logic toggle_en = 1'b0;
    logic [63:0] got_q[$];
    logic [63:0] exp_q[$];

    framebuffer_fragment_feeder dut (
        .aclk              (aclk),
        .resetn            (resetn),
        .confXResolution   (confXResolution),
        .confYResolution   (confYResolution),
        .confEnableScissor (confEnableScissor),
        .confScissorStartX (confScissorStartX),
        .confScissorStartY (confScissorStartY),
        .confScissorEndX   (confScissorEndX),
        .confScissorEndY   (confScissorEndY),
        .cmdClear          (cmdClear),
        .cmdClearColor     (cmdClearColor),
        .cmdBusy           (cmdBusy),
        .s_pix_tvalid      (s_pix_tvalid),
        .s_pix_tready      (s_pix_tready),
        .s_pix_tdata       (s_pix_tdata),
        .s_pix_tstrb       (s_pix_tstrb),
        .s_pix_txpos       (s_pix_txpos),
        .s_pix_typos       (s_pix_typos),
        .s_pix_tlast       (s_pix_tlast),
        .m_frag_tvalid     (m_frag_tvalid),
        .m_frag_tready     (m_frag_tready),
        .m_frag_tdata      (m_frag_tdata),
        .m_frag_tstrb      (m_frag_tstrb),
        .m_frag_tlast      (m_frag_tlast),
        .m_frag_txpos      (m_frag_txpos),
        .m_frag_typos      (m_frag_typos),
        .m_frag_taddr      (m_frag_taddr),
        .dbg_state         (dbg_state)
    );

    // clock
    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    function automatic logic [63:0] pack(input logic last, input logic strb,
                                         input logic [15:0] data, input logic [31:0] addr);
        return {14'd0, last, strb, data, addr};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // output monitor: a transfer seen at the falling edge completes on the next rise
    logic [63:0] held;
    logic        hold = 1'b0;
    always @(negedge aclk) begin
        if (resetn && hold && m_frag_tvalid) begin
            n_cmp++;
            assert (pack(m_frag_tlast, m_frag_tstrb, m_frag_tdata, m_frag_taddr) === held) else begin
                n_fail++;
                $error("FAIL stall_stable: observed %0h expected %0h",
                       pack(m_frag_tlast, m_frag_tstrb, m_frag_tdata, m_frag_taddr), held);
            end
        end
        hold = resetn && m_frag_tvalid && !m_frag_tready;
        held = pack(m_frag_tlast, m_frag_tstrb, m_frag_tdata, m_frag_taddr);
        if (resetn && m_frag_tvalid && m_frag_tready)
            got_q.push_back(pack(m_frag_tlast, m_frag_tstrb, m_frag_tdata, m_frag_taddr));
    end

    task automatic tick();
        @(posedge aclk);
        #1;
        if (toggle_en) m_frag_tready = ~m_frag_tready;
    endtask

    task automatic drive_pix(input logic [XW-1:0] x, input logic [YW-1:0] y,
                             input logic [PW-1:0] d, input logic last);
        s_pix_txpos  = x;
        s_pix_typos  = y;
        s_pix_tdata  = d;
        s_pix_tstrb  = 1'b1;
        s_pix_tlast  = last;
        s_pix_tvalid = 1'b1;
        for (int k = 0; k < 50; k++) begin
            #1;
            if (s_pix_tready) begin
                tick();
                s_pix_tvalid = 1'b0;
                return;
            end
            tick();
        end
        check("pix_accept_timeout", 64'd0, 64'd1);
        s_pix_tvalid = 1'b0;
    endtask

    task automatic pulse_clear(input logic [PW-1:0] color);
        cmdClearColor = color;
        cmdClear      = 1'b1;
        tick();
        cmdClear      = 1'b0;
    endtask

    task automatic wait_frags(input int n);
        for (int k = 0; k < 300; k++) begin
            if (got_q.size() >= n) break;
            tick();
        end
        for (int k = 0; k < 4; k++) tick();
    endtask

    task automatic check_frags(input string tag);
        check({tag, "_count"}, 64'(got_q.size()), 64'(exp_q.size()));
        while (got_q.size() > 0 && exp_q.size() > 0)
            check(tag, got_q.pop_front(), exp_q.pop_front());
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        int cnt;
        resetn = 1'b0;
        confXResolution = 11'd640;
        confYResolution = 11'd480;
        confEnableScissor = 1'b0;
        confScissorStartX = '0; confScissorStartY = '0;
        confScissorEndX = '0;   confScissorEndY = '0;
        cmdClear = 1'b0; cmdClearColor = '0;
        s_pix_tvalid = 1'b0; s_pix_tdata = '0; s_pix_tstrb = 1'b0;
        s_pix_txpos = '0; s_pix_typos = '0; s_pix_tlast = 1'b0;
        m_frag_tready = 1'b1;
        tick(); tick(); tick();

        // reset state
        check("rst_s_tready", 64'(s_pix_tready), 64'd0);
        check("rst_m_tvalid", 64'(m_frag_tvalid), 64'd0);
        resetn = 1'b1;
        tick();
        check("idle_s_tready", 64'(s_pix_tready), 64'd1);
        check("idle_busy", 64'(cmdBusy), 64'd0);
        check("idle_state", 64'(dbg_state), 64'd0);
        check("idle_m_tvalid", 64'(m_frag_tvalid), 64'd0);

        // single pixel (3,2) at xres 640 -> 1283, two cycles after accept
        drive_pix(11'd3, 11'd2, 16'hF800, 1'b1);
        check("lat_cycle1_tvalid", 64'(m_frag_tvalid), 64'd0);
        tick();
        check("lat_cycle2_tvalid", 64'(m_frag_tvalid), 64'd1);
        check("lat_addr", 64'(m_frag_taddr), 64'd1283);
        check("lat_xpos", 64'(m_frag_txpos), 64'd3);
        check("lat_ypos", 64'(m_frag_typos), 64'd2);
        exp_q.push_back(pack(1'b1, 1'b1, 16'hF800, 32'd1283));
        wait_frags(1);
        check_frags("single");

        // 8 back-to-back pixels with output ready toggling
        toggle_en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            drive_pix(11'(i), 11'd1, 16'(16'h0100 + i), (i == 7));
            exp_q.push_back(pack((i == 7), 1'b1, 16'(16'h0100 + i), 32'(640 + i)));
        end
        wait_frags(8);
        toggle_en = 1'b0;
        m_frag_tready = 1'b1;
        check_frags("burst");

        // scissor clear (2,1)-(4,3)
        confEnableScissor = 1'b1;
        confScissorStartX = 11'd2; confScissorStartY = 11'd1;
        confScissorEndX   = 11'd4; confScissorEndY   = 11'd3;
        pulse_clear(16'h1234);
        check("sc_busy_rise", 64'(cmdBusy), 64'd1);
        check("sc_state", 64'(dbg_state), 64'd2);
        check("sc_s_tready", 64'(s_pix_tready), 64'd0);
        for (int k = 0; k < 100 && cmdBusy; k++) tick();
        check("sc_busy_fall", 64'(cmdBusy), 64'd0);
        exp_q.push_back(pack(1'b0, 1'b1, 16'h1234, 32'd642));
        exp_q.push_back(pack(1'b0, 1'b1, 16'h1234, 32'd643));
        exp_q.push_back(pack(1'b0, 1'b1, 16'h1234, 32'd1282));
        exp_q.push_back(pack(1'b1, 1'b1, 16'h1234, 32'd1283));
        check_frags("scissor");

        // clear while a 3-beat packet is open; full 4x2 screen
        confEnableScissor = 1'b0;
        confXResolution = 11'd4;
        confYResolution = 11'd2;
        drive_pix(11'd10, 11'd0, 16'hAAAA, 1'b0);
        pulse_clear(16'h5555);
        check("pend_busy", 64'(cmdBusy), 64'd1);
        check("pend_state", 64'(dbg_state), 64'd1);
        drive_pix(11'd11, 11'd0, 16'hAAAB, 1'b0);
        drive_pix(11'd12, 11'd0, 16'hAAAC, 1'b1);
        check("pend_to_clear", 64'(dbg_state), 64'd2);
        // offer a pixel that must wait until the clear is done
        s_pix_txpos = 11'd13; s_pix_typos = 11'd0; s_pix_tdata = 16'hDEAD;
        s_pix_tlast = 1'b1; s_pix_tvalid = 1'b1;
        for (int k = 0; k < 100; k++) begin
            if (!cmdBusy) break;
            check("clear_s_tready", 64'(s_pix_tready), 64'd0);
            tick();
        end
        s_pix_tvalid = 1'b0;
        check("pend_busy_fall", 64'(cmdBusy), 64'd0);
        exp_q.push_back(pack(1'b0, 1'b1, 16'hAAAA, 32'd10));
        exp_q.push_back(pack(1'b0, 1'b1, 16'hAAAB, 32'd11));
        exp_q.push_back(pack(1'b1, 1'b1, 16'hAAAC, 32'd12));
        for (int i = 0; i < 8; i++)
            exp_q.push_back(pack((i == 7), 1'b1, 16'h5555, 32'(i)));
        wait_frags(11);
        check_frags("pend_clear");

        // empty scissor clear: no fragments, short busy
        confEnableScissor = 1'b1;
        confScissorStartX = 11'd5; confScissorEndX = 11'd5;
        confScissorStartY = 11'd0; confScissorEndY = 11'd3;
        pulse_clear(16'h7777);
        cnt = 0;
        for (int k = 0; k < 20 && cmdBusy; k++) begin
            cnt++;
            tick();
        end
        check("empty_busy_len", 64'((cnt >= 1) && (cnt <= 3)), 64'd1);
        wait_frags(0);
        check_frags("empty");

        // reset mid-clear with the output stalled
        confEnableScissor = 1'b0;
        m_frag_tready = 1'b0;
        pulse_clear(16'h3333);
        tick(); tick(); tick();
        check("stall_tvalid", 64'(m_frag_tvalid), 64'd1);
        check("stall_addr", 64'(m_frag_taddr), 64'd0);
        resetn = 1'b0;
        tick();
        check("abort_tvalid", 64'(m_frag_tvalid), 64'd0);
        check("abort_busy", 64'(cmdBusy), 64'd0);
        check("abort_state", 64'(dbg_state), 64'd0);
        check("abort_s_tready", 64'(s_pix_tready), 64'd0);
        resetn = 1'b1;
        m_frag_tready = 1'b1;
        tick();
        check("post_rst_s_tready", 64'(s_pix_tready), 64'd1);
        wait_frags(0);
        check_frags("abort_no_frags");
        drive_pix(11'd3, 11'd1, 16'h0F0F, 1'b1);
        exp_q.push_back(pack(1'b1, 1'b1, 16'h0F0F, 32'd7));
        wait_frags(1);
        check_frags("post_rst_pix");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
